// File: rtl/seg7_reader_if.sv
// Bus between the seven-segment source and the seg7_reader monitor.
// The master side drives the sampled segment pattern; the slave side
// returns the decoded digit, the classification pulses and the error count.
interface seg7_reader_if #(
    parameter int NBITS_ERR = 8
);
    logic                 sample_en;
    logic [7:0]           seg_in;
    logic [3:0]           digit;
    logic                 digit_valid;
    logic                 step_up;
    logic                 step_down;
    logic                 jump;
    logic                 bad_pattern;
    logic [NBITS_ERR-1:0] err_count;

    modport master (
        output sample_en,
        output seg_in,
        input  digit,
        input  digit_valid,
        input  step_up,
        input  step_down,
        input  jump,
        input  bad_pattern,
        input  err_count
    );

    modport slave (
        input  sample_en,
        input  seg_in,
        output digit,
        output digit_valid,
        output step_up,
        output step_down,
        output jump,
        output bad_pattern,
        output err_count
    );
endinterface

// File: rtl/seg7_reader.sv
// Seven-segment pattern reader: glitch-filters the segment bus, decodes
// accepted patterns back to a hex digit, classifies each new digit as a
// step up, step down or jump, and counts undecodable patterns.
module seg7_reader #(
    parameter int STABLE_CYCLES = 2,
    parameter int NBITS_ERR     = 8
) (
    input  logic           clk_2,
    input  logic           reset,
    seg7_reader_if.slave   bus
);

    localparam logic [3:0] STAB = 4'(STABLE_CYCLES);

    typedef enum logic {
        EMPTY = 1'b0,
        TRACK = 1'b1
    } state_t;

    // Decoded pattern layout: {is_digit, is_blank, value}
    function automatic logic [5:0] decode7(input logic [6:0] p);
        logic [5:0] d;
        case (p)
            7'h3F:   d = {2'b10, 4'h0};
            7'h06:   d = {2'b10, 4'h1};
            7'h5B:   d = {2'b10, 4'h2};
            7'h4F:   d = {2'b10, 4'h3};
            7'h66:   d = {2'b10, 4'h4};
            7'h6D:   d = {2'b10, 4'h5};
            7'h7D:   d = {2'b10, 4'h6};
            7'h07:   d = {2'b10, 4'h7};
            7'h7F:   d = {2'b10, 4'h8};
            7'h6F:   d = {2'b10, 4'h9};
            7'h77:   d = {2'b10, 4'hA};
            7'h7C:   d = {2'b10, 4'hB};
            7'h39:   d = {2'b10, 4'hC};
            7'h5E:   d = {2'b10, 4'hD};
            7'h79:   d = {2'b10, 4'hE};
            7'h71:   d = {2'b10, 4'hF};
            7'h00:   d = {2'b01, 4'h0};
            default: d = {2'b00, 4'h0};
        endcase
        return d;
    endfunction

    // Filter state
    logic [6:0]           r_cand;
    logic [3:0]           r_stab_cnt;
    logic [6:0]           r_last_acc;

    // Tracker state and registered outputs
    state_t               r_state;
    logic [3:0]           r_digit;
    logic                 r_digit_valid;
    logic                 r_step_up;
    logic                 r_step_down;
    logic                 r_jump;
    logic                 r_bad_pattern;
    logic [NBITS_ERR-1:0] r_err_count;

    logic [6:0]           w_pat;
    logic                 w_unused_dp;
    logic [3:0]           w_cnt_next;
    logic                 w_accept;
    logic [5:0]           w_dec;
    logic                 w_is_digit;
    logic                 w_is_blank;
    logic [3:0]           w_value;
    logic [3:0]           w_digit_up;
    logic [3:0]           w_digit_dn;

    // The decimal point carries no digit information.
    assign w_pat       = bus.seg_in[6:0];
    assign w_unused_dp = bus.seg_in[7];

    // Count the current pattern would reach this cycle; a new pattern restarts at 1.
    assign w_cnt_next = (w_pat != r_cand)      ? 4'd1 :
                        (r_stab_cnt >= STAB)   ? STAB :
                                                 r_stab_cnt + 4'd1;

    // Accept once per distinct stable pattern: last_acc blocks re-acceptance.
    assign w_accept = bus.sample_en && (w_cnt_next == STAB) && (w_pat != r_last_acc);

    assign w_dec      = decode7(w_pat);
    assign w_is_digit = w_dec[5];
    assign w_is_blank = w_dec[4];
    assign w_value    = w_dec[3:0];

    // 4-bit arithmetic gives the F->0 and 0->F wrap for free.
    assign w_digit_up = r_digit + 4'd1;
    assign w_digit_dn = r_digit - 4'd1;

    // Stability filter: track the candidate pattern and how long it has held.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_cand     <= 7'h00;
            r_stab_cnt <= 4'd0;
            r_last_acc <= 7'h00;
        end else if (bus.sample_en) begin
            r_cand     <= w_pat;
            r_stab_cnt <= w_cnt_next;
            if (w_accept) begin
                r_last_acc <= w_pat;
            end
        end
    end

    // EMPTY/TRACK state machine with registered digit, pulses and error count.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_state       <= EMPTY;
            r_digit       <= 4'h0;
            r_digit_valid <= 1'b0;
            r_step_up     <= 1'b0;
            r_step_down   <= 1'b0;
            r_jump        <= 1'b0;
            r_bad_pattern <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_step_up     <= 1'b0;
            r_step_down   <= 1'b0;
            r_jump        <= 1'b0;
            r_bad_pattern <= 1'b0;
            if (w_accept) begin
                if (w_is_blank) begin
                    r_digit_valid <= 1'b0;
                    r_state       <= EMPTY;
                end else if (!w_is_digit) begin
                    r_bad_pattern <= 1'b1;
                    if (r_err_count != '1) begin
                        r_err_count <= r_err_count + 1'b1;
                    end
                end else begin
                    r_digit       <= w_value;
                    r_digit_valid <= 1'b1;
                    case (r_state)
                        EMPTY: begin
                            r_state <= TRACK;
                        end
                        TRACK: begin
                            if (w_value == w_digit_up) begin
                                r_step_up <= 1'b1;
                            end else if (w_value == w_digit_dn) begin
                                r_step_down <= 1'b1;
                            end else begin
                                r_jump <= 1'b1;
                            end
                        end
                        default: r_state <= EMPTY;
                    endcase
                end
            end
        end
    end

    assign bus.digit       = r_digit;
    assign bus.digit_valid = r_digit_valid;
    assign bus.step_up     = r_step_up;
    assign bus.step_down   = r_step_down;
    assign bus.jump        = r_jump;
    assign bus.bad_pattern = r_bad_pattern;
    assign bus.err_count   = r_err_count;

endmodule
